// File: rtl/tile_puzzle_engine.sv
// Sliding-tile game engine for the VGA scramble game.
// Holds a GRID x GRID board and shuffles it on request. Applies debounced arrow-button moves
// to the blank tile, detects the solved board and counts legal player moves. Also answers
// per-cell display lookups, one cycle after each request, from the VGA scan.
//
// Ports:
//   vgaclk                    sole clock, rising edge
//   reset                     asynchronous, active-low
//   right/left/up/down_deb    debounced button levels; a rising edge requests a move
//   mode                      rising edge requests a new shuffle
//   pixelEN, cell_h, cell_v   lookup strobe and cell coordinates
//   addr, inv                 tile id of the looked-up cell and the blank/invert flag
//   win                       board solved after at least one player move
//   busy                      shuffle in progress
//   moves                     saturating count of legal player moves since the last shuffle
module tile_puzzle_engine #(
  parameter int unsigned GRID          = 4,
  parameter int unsigned SHUFFLE_MOVES = 256,
  parameter int unsigned MOVE_W        = 10,
  localparam int unsigned NCELL        = GRID * GRID,
  localparam int unsigned TW           = $clog2(NCELL),
  localparam int unsigned CW           = $clog2(GRID)
) (
  input  logic              vgaclk,
  input  logic              reset,
  input  logic              right_deb,
  input  logic              left_deb,
  input  logic              up_deb,
  input  logic              down_deb,
  input  logic              mode,
  input  logic              pixelEN,
  input  logic [CW-1:0]     cell_h,
  input  logic [CW-1:0]     cell_v,
  output logic [TW-1:0]     addr,
  output logic              inv,
  output logic              win,
  output logic              busy,
  output logic [MOVE_W-1:0] moves
);

  localparam logic [TW-1:0]     BL       = TW'(NCELL - 1);
  localparam int unsigned       SCW      = $clog2(SHUFFLE_MOVES + 1);
  localparam logic [MOVE_W-1:0] MOVE_MAX = '1;

  typedef enum logic [1:0] {StPlay, StShuffle, StWin} state_e;

  state_e          state_q;
  logic [TW-1:0]   board_q [NCELL];
  logic [TW-1:0]   blank_q;
  logic [15:0]     lfsr_q;
  logic [4:0]      prev_q;   // {right, left, up, down, mode} from the previous cycle
  logic [SCW-1:0]  scnt_q;

  logic [4:0]      in_vec;
  logic [4:0]      edges;
  logic            mv_req;
  logic [1:0]      mv_dir;   // 0 right, 1 left, 2 up, 3 down
  int unsigned     row, col, bp;
  logic            nb_ok;
  logic [TW-1:0]   nb;
  logic            legal;
  logic            solved;
  logic            win_now;
  int unsigned     ih, iv;
  logic            in_range;
  logic [TW-1:0]   lidx;

  assign in_vec = {right_deb, left_deb, up_deb, down_deb, mode};
  assign edges  = in_vec & ~prev_q;

  always_comb begin
    solved = 1'b1;
    for (int i = 0; i < int'(NCELL); i++) begin
      if (board_q[i] != TW'(i)) solved = 1'b0;
    end
  end

  assign win_now = solved && (moves != '0);

  // Pick at most one move request per cycle; a pending win or shuffle request wins over moves.
  always_comb begin
    mv_req = 1'b0;
    mv_dir = 2'd0;
    if (state_q == StShuffle) begin
      mv_req = 1'b1;
      mv_dir = lfsr_q[1:0];
    end else if (state_q == StPlay && !win_now && !edges[0]) begin
      if (edges[4]) begin
        mv_req = 1'b1;
        mv_dir = 2'd0;
      end else if (edges[3]) begin
        mv_req = 1'b1;
        mv_dir = 2'd1;
      end else if (edges[2]) begin
        mv_req = 1'b1;
        mv_dir = 2'd2;
      end else if (edges[1]) begin
        mv_req = 1'b1;
        mv_dir = 2'd3;
      end
    end
  end

  always_comb begin
    bp    = 32'(blank_q);
    row   = bp / GRID;
    col   = bp % GRID;
    nb_ok = 1'b0;
    nb    = blank_q;
    unique case (mv_dir)
      2'd0: if (col + 1 < GRID) begin nb_ok = 1'b1; nb = TW'(bp + 1);    end
      2'd1: if (col > 0)        begin nb_ok = 1'b1; nb = TW'(bp - 1);    end
      2'd2: if (row > 0)        begin nb_ok = 1'b1; nb = TW'(bp - GRID); end
      2'd3: if (row + 1 < GRID) begin nb_ok = 1'b1; nb = TW'(bp + GRID); end
      default: nb_ok = 1'b0;
    endcase
  end

  assign legal = mv_req && nb_ok;

  always_comb begin
    ih       = 32'(cell_h);
    iv       = 32'(cell_v);
    in_range = (ih < GRID) && (iv < GRID);
    lidx     = TW'(iv * GRID + ih);
  end

  always_ff @(posedge vgaclk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(NCELL); i++) board_q[i] <= TW'(i);
      blank_q <= BL;
      state_q <= StPlay;
      lfsr_q  <= 16'hACE1;
      prev_q  <= '1;
      scnt_q  <= '0;
      moves   <= '0;
      win     <= 1'b0;
      busy    <= 1'b0;
      addr    <= '0;
      inv     <= 1'b0;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      prev_q <= in_vec;

      // Lookup sees the board as it was before any swap made in this cycle.
      if (pixelEN) begin
        if (in_range) begin
          addr <= board_q[lidx];
          inv  <= (lidx == blank_q) && !win;
        end else begin
          addr <= BL;
          inv  <= 1'b0;
        end
      end

      if (legal) begin
        board_q[blank_q] <= board_q[nb];
        board_q[nb]      <= BL;
        blank_q          <= nb;
      end

      case (state_q)
        StPlay: begin
          if (win_now) begin
            state_q <= StWin;
            win     <= 1'b1;
          end else if (edges[0]) begin
            state_q <= StShuffle;
            busy    <= 1'b1;
            scnt_q  <= '0;
          end else if (legal && moves != MOVE_MAX) begin
            moves <= moves + 1'b1;
          end
        end
        StShuffle: begin
          if (scnt_q == SCW'(SHUFFLE_MOVES - 1)) begin
            state_q <= StPlay;
            busy    <= 1'b0;
            moves   <= '0;
          end else begin
            scnt_q <= scnt_q + 1'b1;
          end
        end
        StWin: begin
          if (edges[0]) begin
            state_q <= StShuffle;
            win     <= 1'b0;
            busy    <= 1'b1;
            scnt_q  <= '0;
          end
        end
        default: state_q <= StPlay;
      endcase
    end
  end

endmodule
